// File: rtl/tpu_host_sequencer_pkg.sv
// Shared types and helpers for the tpu_simple host-side sequencer.
// The lane index helper gives the position of matrix element (r,c) in the flattened operand buses.
package tpu_host_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_KICK,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned size);
        return r * size + c;
    endfunction

    function automatic logic cfg_ok(input logic [7:0] n, input int unsigned size);
        return (n != 8'd0) && (32'(n) <= size);
    endfunction

endpackage

// File: rtl/tpu_host_sequencer_if.sv
// Host-facing job control, element input stream and result output stream.
// The master modport is the host link side; the slave modport is the sequencer side.
interface tpu_host_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    logic [7:0]            cfg_size;
    logic                  job_start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  job_busy;
    logic                  job_done;
    logic                  err;

    modport master (
        output cfg_size, job_start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, job_busy, job_done, err
    );

    modport slave (
        input  cfg_size, job_start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, job_busy, job_done, err
    );
endinterface

// File: rtl/tpu_host_sequencer_rc_counter.sv
// Row/column position counter for an n x n matrix walk: column steps first, both wrap at n.
// The last flag marks position (n-1, n-1).
module tpu_host_sequencer_rc_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic [CW-1:0] n,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    logic [CW-1:0] n_m1;

    assign n_m1 = n - CW'(1);
    assign last = (row == n_m1) && (col == n_m1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == n_m1) begin
                col <= '0;
                row <= (row == n_m1) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end
endmodule

// File: rtl/tpu_host_sequencer.sv
// Drives tpu_simple through one load/start/wait/read job per host request.
// state    | meaning
// IDLE     | waiting for job_start; bad cfg_size pulses err
// LOAD_A   | accepting n*n A elements, row-major
// LOAD_B   | accepting n*n B elements, row-major
// KICK     | tpu_start high for this single cycle
// WAIT     | waiting for tpu_done under the watchdog
// DRAIN    | streaming C out row-major, last on C(n-1,n-1)
module tpu_host_sequencer
    import tpu_host_sequencer_pkg::*;
#(
    parameter int SIZE           = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    tpu_host_sequencer_if.slave             host,
    output logic                            tpu_start,
    output logic [7:0]                      tpu_size,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] tpu_a,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] tpu_b,
    input  logic [SIZE*SIZE*ACC_WIDTH-1:0]  tpu_c,
    input  logic                            tpu_busy,
    input  logic                            tpu_done
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int NL = SIZE * SIZE;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;

    state_t                state;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  rc_last;
    logic [WW-1:0]         wd;
    logic [LW-1:0]         lane;
    logic                  xfer_in;
    logic                  xfer_out;
    logic                  start_ok;
    logic                  unused_busy;
    logic [DATA_WIDTH-1:0] a_mem [NL];
    logic [DATA_WIDTH-1:0] b_mem [NL];
    logic [ACC_WIDTH-1:0]  c_mem [NL];

    assign unused_busy = tpu_busy;
    assign lane        = LW'(idx(32'(row), 32'(col), SIZE));
    assign xfer_in     = host.in_valid && host.in_ready;
    assign xfer_out    = host.out_valid && host.out_ready;
    assign start_ok    = (state == ST_IDLE) && host.job_start && cfg_ok(host.cfg_size, SIZE);

    // One counter walks A, then B, then C; it wraps to (0,0) at each matrix end.
    tpu_host_sequencer_rc_counter #(.CW(CW)) u_rc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .en    (xfer_in || xfer_out),
        .n     (n_q),
        .row   (row),
        .col   (col),
        .last  (rc_last)
    );

    for (genvar i = 0; i < NL; i++) begin : g_lane
        assign tpu_a[i*DATA_WIDTH +: DATA_WIDTH] = a_mem[i];
        assign tpu_b[i*DATA_WIDTH +: DATA_WIDTH] = b_mem[i];
    end

    assign host.out_data = host.out_valid ? c_mem[lane] : '0;
    assign host.out_last = host.out_valid && rc_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            n_q           <= '0;
            tpu_size      <= '0;
            tpu_start     <= 1'b0;
            wd            <= '0;
            host.in_ready  <= 1'b0;
            host.out_valid <= 1'b0;
            host.job_busy  <= 1'b0;
            host.job_done  <= 1'b0;
            host.err       <= 1'b0;
            for (int i = 0; i < NL; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
                c_mem[i] <= '0;
            end
        end else begin
            tpu_start     <= 1'b0;
            host.job_done <= 1'b0;
            host.err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        tpu_size      <= host.cfg_size;
                        n_q           <= host.cfg_size[CW-1:0];
                        host.in_ready <= 1'b1;
                        host.job_busy <= 1'b1;
                        state         <= ST_LOAD_A;
                        for (int i = 0; i < NL; i++) begin
                            a_mem[i] <= '0;
                            b_mem[i] <= '0;
                        end
                    end else if (host.job_start) begin
                        host.err <= 1'b1;
                    end
                end
                ST_LOAD_A: begin
                    if (xfer_in) begin
                        a_mem[lane] <= host.in_data;
                        if (rc_last) state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (xfer_in) begin
                        b_mem[lane] <= host.in_data;
                        if (rc_last) begin
                            host.in_ready <= 1'b0;
                            tpu_start     <= 1'b1;
                            state         <= ST_KICK;
                        end
                    end
                end
                ST_KICK: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tpu_done) begin
                        for (int i = 0; i < NL; i++) c_mem[i] <= tpu_c[i*ACC_WIDTH +: ACC_WIDTH];
                        host.out_valid <= 1'b1;
                        state          <= ST_DRAIN;
                    end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        host.err      <= 1'b1;
                        host.job_busy <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (xfer_out && rc_last) begin
                        host.out_valid <= 1'b0;
                        host.job_done  <= 1'b1;
                        host.job_busy  <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Self-checking bench: behavioural tpu_simple core (done 8 cycles after start) and a matrix-product reference.
module tb_tpu_host_sequencer;
    localparam int SIZE = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_host_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) hif ();

    logic                      tpu_start;
    logic [7:0]                tpu_size;
    logic [SIZE*SIZE*DW-1:0]   tpu_a;
    logic [SIZE*SIZE*DW-1:0]   tpu_b;
    logic [SIZE*SIZE*AW-1:0]   tpu_c;
    logic                      tpu_busy;
    logic                      tpu_done;

    tpu_host_sequencer #(
        .SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (hif),
        .tpu_start (tpu_start),
        .tpu_size  (tpu_size),
        .tpu_a     (tpu_a),
        .tpu_b     (tpu_b),
        .tpu_c     (tpu_c),
        .tpu_busy  (tpu_busy),
        .tpu_done  (tpu_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit core_hang = 1'b0;
    int core_cnt  = 0;
    int ma [16];
    int mb [16];
    int mn = 0;
    int got_d [$];
    bit got_l [$];
    int stab_bad = 0;
    int start_pulses = 0, start_width = 0, start_run = 0, done_pulses = 0;

    // Behavioural core: multiplies whatever operands it sees on tpu_a/tpu_b.
    assign tpu_busy = (core_cnt != 0);
    always @(posedge clk) begin
        logic [SIZE*SIZE*AW-1:0] cv;
        int sa, sb, acc, nn;
        tpu_done <= 1'b0;
        if (!rst_n) begin
            core_cnt = 0;
        end else if (tpu_start && !core_hang) begin
            core_cnt = 8;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                nn = int'(tpu_size);
                cv = '0;
                for (int r = 0; r < SIZE; r++)
                    for (int c = 0; c < SIZE; c++) begin
                        acc = 0;
                        if (r < nn && c < nn)
                            for (int k = 0; k < nn; k++) begin
                                sa = $signed(tpu_a[(r*SIZE+k)*DW +: DW]);
                                sb = $signed(tpu_b[(k*SIZE+c)*DW +: DW]);
                                acc += sa * sb;
                            end
                        cv[(r*SIZE+c)*AW +: AW] = acc;
                    end
                tpu_c    <= cv;
                tpu_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (tpu_start) start_run++;
        else begin
            if (start_run > 0) begin
                start_pulses++;
                start_width = start_run;
            end
            start_run = 0;
        end
        if (hif.job_done === 1'b1) done_pulses++;
    end

    function automatic int exp_c(int r, int c);
        int s = 0;
        for (int k = 0; k < mn; k++) s += ma[r*SIZE+k] * mb[k*SIZE+c];
        return s;
    endfunction

    task automatic set_mats(input int n, input int a0, a1, a2, a3, b0, b1, b2, b3);
        for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; end
        mn = n;
        ma[0] = a0; ma[1] = a1; ma[SIZE] = a2; ma[SIZE+1] = a3;
        mb[0] = b0; mb[1] = b1; mb[SIZE] = b2; mb[SIZE+1] = b3;
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        hif.cfg_size  = 8'(n);
        hif.job_start = 1'b1;
        @(negedge clk);
        hif.job_start = 1'b0;
    endtask

    task automatic load_job(input bit gaps, input int nx, output bit to);
        int k = 0, cyc = 0, e;
        bit x;
        while (k < nx && cyc < 400) begin
            hif.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            e = (k < mn*mn) ? k : k - mn*mn;
            hif.in_data = (k < mn*mn) ? 8'(ma[(e/mn)*SIZE + e%mn]) : 8'(mb[(e/mn)*SIZE + e%mn]);
            x = hif.in_valid && hif.in_ready;
            @(negedge clk);
            cyc++;
            if (x) k++;
        end
        hif.in_valid = 1'b0;
        to = (k < nx);
    endtask

    task automatic collect(input bit stall, output bit to);
        int p = 0, cyc = 0;
        bit fin = 0, pstall = 0;
        logic [AW-1:0] pd = '0;
        logic pl = 1'b0;
        got_d.delete();
        got_l.delete();
        while (!fin && cyc < 300) begin
            hif.out_ready = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            if (hif.out_valid) begin
                if (pstall && (hif.out_data !== pd || hif.out_last !== pl)) stab_bad++;
                pd = hif.out_data;
                pl = hif.out_last;
                pstall = !hif.out_ready;
                p++;
                if (hif.out_ready) begin
                    got_d.push_back(int'($signed(hif.out_data)));
                    got_l.push_back(hif.out_last);
                    if (hif.out_last) fin = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        hif.out_ready = 1'b0;
        to = !fin;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hif.in_ready, hif.out_valid, hif.out_last, hif.job_busy, hif.job_done, hif.err, tpu_start} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {hif.in_ready, hif.out_valid, hif.out_last, hif.job_busy, hif.job_done, hif.err, tpu_start});
        end
        n_checks++;
        if (tpu_a !== '0 || tpu_b !== '0 || tpu_size !== 8'd0 || hif.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: got a=%h b=%h size=%0d out=%0d expected all 0", tpu_a, tpu_b, tpu_size, hif.out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to1, to2;
        int d0 = done_pulses;
        logic [SIZE*SIZE*DW-1:0] ea = '0;
        set_mats(2, 1, 2, 3, 4, 5, 6, 7, 8);
        start_job(2);
        load_job(1'b0, 8, to1);
        collect(1'b0, to2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (to1 || to2 || got_d.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results (timeouts %0d/%0d) expected 4", got_d.size(), to1, to2);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_d[i] !== exp_c(i/2, i%2) || got_l[i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL basic_result[%0d]: got %0d last=%0d expected %0d last=%0d",
                             i, got_d[i], got_l[i], exp_c(i/2, i%2), (i == 3));
                end
            end
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) ea[(r*SIZE+c)*DW +: DW] = 8'(ma[r*SIZE+c]);
        n_checks++;
        if (tpu_a !== ea) begin
            n_fail++;
            $display("FAIL basic_tpu_a: got %h expected %h", tpu_a, ea);
        end
        n_checks++;
        if (tpu_size !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_tpu_size: got %0d expected 2", tpu_size);
        end
        n_checks++;
        if (done_pulses - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_job_done: got %0d pulses expected 1", done_pulses - d0);
        end
    endtask

    task automatic test_identity();
        bit to1, to2;
        int s0 = start_pulses;
        set_mats(2, 5, 6, 7, 8, 1, 0, 0, 1);
        start_job(2);
        load_job(1'b0, 8, to1);
        collect(1'b0, to2);
        n_checks++;
        if (to1 || to2 || got_d.size() != 4) begin
            n_fail++;
            $display("FAIL ident_count: got %0d results expected 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_d[i] !== 5 + i) begin
                    n_fail++;
                    $display("FAIL ident_result[%0d]: got %0d expected %0d", i, got_d[i], 5 + i);
                end
            end
        end
        n_checks++;
        if (start_pulses - s0 != 1 || start_width != 1) begin
            n_fail++;
            $display("FAIL ident_start: got %0d pulses width %0d expected 1 pulse width 1", start_pulses - s0, start_width);
        end
    endtask

    task automatic test_stall();
        bit to1, to2;
        stab_bad = 0;
        set_mats(2, 1, 2, 3, 4, 5, 6, 7, 8);
        start_job(2);
        load_job(1'b1, 8, to1);
        collect(1'b1, to2);
        n_checks++;
        if (to1 || to2 || got_d.size() != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results expected 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_d[i] !== exp_c(i/2, i%2) || got_l[i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL stall_result[%0d]: got %0d expected %0d", i, got_d[i], exp_c(i/2, i%2));
                end
            end
        end
        n_checks++;
        if (stab_bad != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d changes while stalled expected 0", stab_bad);
        end
    endtask

    task automatic test_bad_cfg();
        int s0 = start_pulses;
        int bad [2];
        bad[0] = 0;
        bad[1] = SIZE + 1;
        for (int i = 0; i < 2; i++) begin
            start_job(bad[i]);
            n_checks++;
            if (hif.err !== 1'b1 || hif.in_ready !== 1'b0 || hif.job_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL badcfg_%0d: got err=%b in_ready=%b busy=%b expected 1 0 0",
                         bad[i], hif.err, hif.in_ready, hif.job_busy);
            end
            @(negedge clk);
            n_checks++;
            if (hif.err !== 1'b0 || hif.job_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL badcfg_%0d_pulse: got err=%b busy=%b expected 0 0", bad[i], hif.err, hif.job_busy);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (start_pulses != s0 || tpu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL badcfg_start: got %0d pulses expected 0", start_pulses - s0);
        end
    endtask

    task automatic test_timeout();
        bit to1, to2, sawv = 0;
        int cyc = 0;
        core_hang = 1'b1;
        set_mats(1, 7, 0, 0, 0, 2, 0, 0, 0);
        start_job(1);
        load_job(1'b0, 2, to1);
        while (tpu_start !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (hif.err !== 1'b1 && cyc < 40) begin
            if (hif.out_valid) sawv = 1;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (to1 || cyc != TMO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got err after %0d cycles expected %0d", cyc, TMO + 1);
        end
        n_checks++;
        if (sawv || hif.job_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got out_valid_seen=%0d busy=%b expected 0 0", sawv, hif.job_busy);
        end
        core_hang = 1'b0;
        set_mats(1, -3, 0, 0, 0, 4, 0, 0, 0);
        start_job(1);
        load_job(1'b0, 2, to1);
        collect(1'b0, to2);
        n_checks++;
        if (to1 || to2 || got_d.size() != 1 || got_d[0] !== -12 || got_l[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0d results first=%0d expected 1 result -12 last",
                     got_d.size(), (got_d.size() > 0) ? got_d[0] : 0);
        end
    endtask

    task automatic test_reset_mid();
        bit to1, to2;
        set_mats(2, 1, 2, 3, 4, 5, 6, 7, 8);
        start_job(2);
        load_job(1'b0, 5, to1);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (to1 || {hif.in_ready, hif.out_valid, hif.job_busy, hif.err, tpu_start} !== 5'b0 ||
            tpu_a !== '0 || tpu_b !== '0 || tpu_size !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset: got flags=%b a=%h b=%h size=%0d expected all 0",
                     {hif.in_ready, hif.out_valid, hif.job_busy, hif.err, tpu_start}, tpu_a, tpu_b, tpu_size);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_job(2);
        load_job(1'b0, 8, to1);
        collect(1'b0, to2);
        n_checks++;
        if (to1 || to2 || got_d.size() != 4 || got_d[0] !== 19 || got_d[1] !== 22 ||
            got_d[2] !== 43 || got_d[3] !== 50) begin
            n_fail++;
            $display("FAIL midreset_rerun: got %0d results expected 19 22 43 50", got_d.size());
        end
    endtask

    task automatic test_random();
        bit to1, to2, g;
        for (int it = 0; it < 4; it++) begin
            mn = $urandom_range(1, SIZE);
            for (int i = 0; i < 16; i++) begin
                ma[i] = ((i / SIZE) < mn && (i % SIZE) < mn) ? int'($urandom_range(0, 255)) - 128 : 0;
                mb[i] = ((i / SIZE) < mn && (i % SIZE) < mn) ? int'($urandom_range(0, 255)) - 128 : 0;
            end
            g = 1'($urandom_range(0, 1));
            start_job(mn);
            load_job(g, 2*mn*mn, to1);
            collect(g, to2);
            n_checks++;
            if (to1 || to2 || got_d.size() != mn*mn) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d results expected %0d", it, got_d.size(), mn*mn);
            end else begin
                for (int i = 0; i < mn*mn; i++) begin
                    n_checks++;
                    if (got_d[i] !== exp_c(i/mn, i%mn) || got_l[i] !== (i == mn*mn-1)) begin
                        n_fail++;
                        $display("FAIL rand%0d_result[%0d]: got %0d expected %0d", it, i, got_d[i], exp_c(i/mn, i%mn));
                    end
                end
            end
        end
    endtask

    initial begin
        hif.cfg_size  = 8'd0;
        hif.job_start = 1'b0;
        hif.in_valid  = 1'b0;
        hif.in_data   = '0;
        hif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_identity();
        test_stall();
        test_bad_cfg();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 500000 time units");
        $fatal(1, "bench time limit");
    end
endmodule
